// File: rtl/halut_result_collector_if.sv
// halut_result_collector_if
// Output stream of the result collector: FP32 result, decoder index and
// row-complete marker, carried over a valid/ready handshake.
// master: the collector (drives data/m_addr/last/valid).
// slave:  the output writer / DMA (drives ready).
interface halut_result_collector_if #(
  parameter int unsigned AddrWidth = 2
);
  logic [31:0]          data;
  logic [AddrWidth-1:0] m_addr;
  logic                 last;
  logic                 valid;
  logic                 ready;

  modport master (
    output data,
    output m_addr,
    output last,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  m_addr,
    input  last,
    input  valid,
    output ready
  );
endinterface

// File: rtl/halut_result_collector.sv
// halut_result_collector
// Collects the decoder array's FP32 result stream, which has no backpressure,
// into a first-word-fall-through FIFO and drains it over a valid/ready
// stream (out_if). Results arriving while the FIFO is full and not popping
// are dropped and flagged in the sticky overflow_o.
// Optional feature macro: HALUT_COLLECTOR_SEQ_CHECK_EN enables an m_addr
// sequence tracker driving the sticky seq_err_o (tied to 0 otherwise).
// DecoderUnits defaults to 4, the decoder array size used in this project.
module halut_result_collector #(
  parameter int unsigned DecoderUnits = 4,
  parameter int unsigned Depth        = 8,
  parameter int unsigned DecAddrWidth = $clog2(DecoderUnits),
  parameter int unsigned CntWidth     = $clog2(Depth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [31:0]             in_result_i,
  input  logic                    in_valid_i,
  input  logic [DecAddrWidth-1:0] in_m_addr_i,
  halut_result_collector_if.master out_if,
  output logic [CntWidth-1:0]     fill_o,
  output logic                    overflow_o,
  output logic                    seq_err_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam logic [CntWidth-1:0] FullCount = CntWidth'(Depth);
  localparam logic [DecAddrWidth-1:0] LastAddr = DecAddrWidth'(DecoderUnits - 1);

  logic [31:0]             data_mem_r [Depth];
  logic [DecAddrWidth-1:0] addr_mem_r [Depth];
  logic [PtrWidth-1:0]     wr_ptr_r;
  logic [PtrWidth-1:0]     rd_ptr_r;
  logic [CntWidth-1:0]     count_r;
  logic [CntWidth-1:0]     count_next_s;
  logic                    overflow_r;
  logic                    not_empty_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;

  // A clear cycle suppresses every push, pop and drop so it cannot touch state.
  assign not_empty_s = (count_r != {CntWidth{1'b0}});
  assign pop_s  = !clear_i && not_empty_s && out_if.ready;
  assign push_s = !clear_i && in_valid_i && ((count_r != FullCount) || pop_s);
  assign drop_s = !clear_i && in_valid_i && (count_r == FullCount) && !pop_s;

  // Fill-level update: push and pop together leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CntWidth'(1);
      2'b01:   count_next_s = count_r - CntWidth'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Entry storage; reset to zero so the head fields are defined after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        data_mem_r[i] <= 32'h0000_0000;
        addr_mem_r[i] <= {DecAddrWidth{1'b0}};
      end
    end else if (push_s) begin
      data_mem_r[wr_ptr_r] <= in_result_i;
      addr_mem_r[wr_ptr_r] <= in_m_addr_i;
    end
  end

  // Pointers (wrap naturally, Depth is a power of two), count and overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= {PtrWidth{1'b0}};
      rd_ptr_r   <= {PtrWidth{1'b0}};
      count_r    <= {CntWidth{1'b0}};
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_r   <= {PtrWidth{1'b0}};
      rd_ptr_r   <= {PtrWidth{1'b0}};
      count_r    <= {CntWidth{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PtrWidth'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrWidth'(1);
      count_r <= count_next_s;
      if (drop_s) overflow_r <= 1'b1;
    end
  end

  // Head of the FIFO is read combinationally (first-word fall-through).
  assign out_if.data   = data_mem_r[rd_ptr_r];
  assign out_if.m_addr = addr_mem_r[rd_ptr_r];
  assign out_if.last   = (addr_mem_r[rd_ptr_r] == LastAddr);
  assign out_if.valid  = not_empty_s;
  assign fill_o        = count_r;
  assign overflow_o    = overflow_r;

`ifdef HALUT_COLLECTOR_SEQ_CHECK_EN
  logic [DecAddrWidth-1:0] exp_addr_r;
  logic                    seq_err_r;

  // Sequence tracker: every valid result (pushed or dropped) must carry the
  // expected m_addr; an idle cycle restarts the expected burst at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_addr_r <= {DecAddrWidth{1'b0}};
      seq_err_r  <= 1'b0;
    end else if (clear_i) begin
      exp_addr_r <= {DecAddrWidth{1'b0}};
      seq_err_r  <= 1'b0;
    end else if (in_valid_i) begin
      if (in_m_addr_i != exp_addr_r) seq_err_r <= 1'b1;
      if (in_m_addr_i == LastAddr) begin
        exp_addr_r <= {DecAddrWidth{1'b0}};
      end else begin
        exp_addr_r <= in_m_addr_i + DecAddrWidth'(1);
      end
    end else begin
      exp_addr_r <= {DecAddrWidth{1'b0}};
    end
  end

  assign seq_err_o = seq_err_r;
`else
  assign seq_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_halut_result_collector.sv
// tb_halut_result_collector
// Directed bench for halut_result_collector (DecoderUnits=4, Depth=8).
// Expected seq_err_o follows HALUT_COLLECTOR_SEQ_CHECK_EN.
module tb_halut_result_collector;

`ifdef HALUT_COLLECTOR_SEQ_CHECK_EN
  localparam logic SeqEn = 1'b1;
`else
  localparam logic SeqEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [31:0] in_result;
  logic        in_valid;
  logic [1:0]  in_m_addr;
  logic [3:0]  fill;
  logic        overflow;
  logic        seq_err;

  int vectors_applied = 0;
  int miscompares     = 0;

  halut_result_collector_if #(.AddrWidth(2)) out_if ();

  halut_result_collector #(
    .DecoderUnits(4),
    .Depth(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .in_result_i(in_result),
    .in_valid_i (in_valid),
    .in_m_addr_i(in_m_addr),
    .out_if     (out_if),
    .fill_o     (fill),
    .overflow_o (overflow),
    .seq_err_o  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors_applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [31:0] d);
    in_valid  = v;
    in_m_addr = a;
    in_result = d;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_if.ready = 1'b0;
    drive(1'b0, 2'd0, 32'h0);
    #2;
    // Reset state
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_valid", 32'(out_if.valid), 32'd0);
    chk("rst_data", out_if.data, 32'h0);
    chk("rst_maddr", 32'(out_if.m_addr), 32'd0);
    chk("rst_last", 32'(out_if.last), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Burst 0..3 with ready high: each result shows up one cycle after push
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 32'h3F80_0000 + 32'(i));
      step();
      chk("b_valid", 32'(out_if.valid), 32'd1);
      chk("b_fill", 32'(fill), 32'd1);
      chk("b_data", out_if.data, 32'h3F80_0000 + 32'(i));
      chk("b_maddr", 32'(out_if.m_addr), 32'(i));
      chk("b_last", 32'(out_if.last), (i == 3) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    chk("b_empty", 32'(out_if.valid), 32'd0);
    chk("b_fill0", 32'(fill), 32'd0);
    chk("b_ovf", 32'(overflow), 32'd0);
    chk("b_seq", 32'(seq_err), 32'd0);

    // Fill to 8 with ready low
    out_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 32'h4000_0000 + 32'(i));
      step();
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    chk("f_fill8", 32'(fill), 32'd8);
    chk("f_head", out_if.data, 32'h4000_0000);
    chk("f_ovf0", 32'(overflow), 32'd0);

    // Full with push and pop together: level stays 8, head advances
    out_if.ready = 1'b1;
    drive(1'b1, 2'd0, 32'h5000_0000);
    step();
    out_if.ready = 1'b0;
    chk("fp_fill", 32'(fill), 32'd8);
    chk("fp_head", out_if.data, 32'h4000_0001);
    chk("fp_ovf", 32'(overflow), 32'd0);

    // Push while full without pop: dropped, overflow next cycle
    drive(1'b1, 2'd1, 32'hDEAD_BEEF);
    chk("d_ovf_before", 32'(overflow), 32'd0);
    step();
    drive(1'b0, 2'd0, 32'h0);
    chk("d_ovf", 32'(overflow), 32'd1);
    chk("d_fill", 32'(fill), 32'd8);

    // Drain: remaining first values unchanged, then the full-cycle push
    out_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("dr_valid", 32'(out_if.valid), 32'd1);
      chk("dr_data", out_if.data, (i == 7) ? 32'h5000_0000 : 32'h4000_0001 + 32'(i));
      chk("dr_maddr", 32'(out_if.m_addr), (i == 7) ? 32'd0 : 32'((i + 1) % 4));
      step();
    end
    chk("dr_empty", 32'(out_if.valid), 32'd0);
    chk("dr_fill", 32'(fill), 32'd0);
    chk("dr_ovf_sticky", 32'(overflow), 32'd1);
    chk("dr_seq", 32'(seq_err), 32'd0);

    // Clear with 5 entries, overflow set and a concurrent input
    out_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'(i % 4), 32'h6000_0000 + 32'(i));
      step();
    end
    chk("c_fill5", 32'(fill), 32'd5);
    clear = 1'b1;
    drive(1'b1, 2'd1, 32'h7000_0000);
    step();
    clear = 1'b0;
    drive(1'b0, 2'd0, 32'h0);
    chk("c_fill", 32'(fill), 32'd0);
    chk("c_valid", 32'(out_if.valid), 32'd0);
    chk("c_ovf", 32'(overflow), 32'd0);
    step();
    chk("c_fill_hold", 32'(fill), 32'd0);

    // Asynchronous reset mid-burst with 3 entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 32'h8000_0000 + 32'(i));
      step();
    end
    drive(1'b0, 2'd0, 32'h0);
    chk("ar_fill3", 32'(fill), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_fill", 32'(fill), 32'd0);
    chk("ar_valid", 32'(out_if.valid), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_fill_after", 32'(fill), 32'd0);

    // Sequence 0,1,3
    out_if.ready = 1'b1;
    drive(1'b1, 2'd0, 32'h1); step();
    drive(1'b1, 2'd1, 32'h2); step();
    chk("s_ok2", 32'(seq_err), 32'd0);
    drive(1'b1, 2'd3, 32'h3); step();
    drive(1'b0, 2'd0, 32'h0);
    chk("s_err", 32'(seq_err), 32'(SeqEn));
    step();
    chk("s_sticky", 32'(seq_err), 32'(SeqEn));
    clear = 1'b1; step(); clear = 1'b0;
    chk("s_clr", 32'(seq_err), 32'd0);

    // Sequence 0,1, gap, 0,1: gap restarts the burst, no error
    drive(1'b1, 2'd0, 32'h1); step();
    drive(1'b1, 2'd1, 32'h2); step();
    drive(1'b0, 2'd0, 32'h0); step();
    drive(1'b1, 2'd0, 32'h3); step();
    drive(1'b1, 2'd1, 32'h4); step();
    drive(1'b0, 2'd0, 32'h0); step();
    chk("s_gap", 32'(seq_err), 32'd0);
    chk("s_ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
